// File: rtl/adc128s_fc_if.sv
// adc128s_fc_if: SPI bus bundle between the Segway controller and the A2D model
interface adc128s_fc_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;
  modport master(output SS_n, SCLK, MOSI, input MISO);
  modport slave(input SS_n, SCLK, MOSI, output MISO);
endinterface

// File: rtl/adc128s_fc.sv
// adc128s_fc: SPI-slave model of an 8-channel 12-bit A2D; ADC_TRISTATE_EN floats MISO while deselected
module adc128s_fc #(
  parameter logic [2:0] CH_LFT   = 3'd0,
  parameter logic [2:0] CH_RGHT  = 3'd4,
  parameter logic [2:0] CH_STEER = 3'd5,
  parameter logic [2:0] CH_BATT  = 3'd6
) (
  input  logic        clk,
  input  logic        rst,
  adc128s_fc_if.slave spi,
  input  logic [11:0] ld_cell_lft,
  input  logic [11:0] ld_cell_rght,
  input  logic [11:0] steerPot,
  input  logic [11:0] batt
);
  logic [2:0]  ss_q, sclk_q;
  logic [1:0]  mosi_q;
  logic [15:0] rx_shft, tx_shft;
  logic [4:0]  bit_cnt;
  logic [2:0]  chnl, nxt_chnl;
  logic [11:0] result, sel;
  logic        ss_fall, ss_rise, sclk_rise, sclk_fall, ss_low, frame_ok;
  logic        unused_rx;
  assign ss_low    = ~ss_q[1];
  assign ss_fall   = ss_q[2] & ~ss_q[1];
  assign ss_rise   = ~ss_q[2] & ss_q[1];
  assign sclk_rise = ~sclk_q[2] & sclk_q[1];
  assign sclk_fall = sclk_q[2] & ~sclk_q[1];
  assign frame_ok  = ss_rise & (bit_cnt == 5'd16);
  assign nxt_chnl  = frame_ok ? rx_shft[13:11] : chnl;
  assign unused_rx = ^{rx_shft[15:14], rx_shft[10:0]};
  // Channel value for the channel that will be latched
  always_comb
    sel = (nxt_chnl == CH_LFT)   ? ld_cell_lft  :
          (nxt_chnl == CH_RGHT)  ? ld_cell_rght :
          (nxt_chnl == CH_STEER) ? steerPot     :
          (nxt_chnl == CH_BATT)  ? batt         : 12'h000;
  // Two-flop synchronisers plus an edge-detect stage; SS_n idles high after reset
  always_ff @(posedge clk)
    if (rst) begin
      ss_q   <= 3'b111;
      sclk_q <= 3'b000;
      mosi_q <= 2'b00;
    end else begin
      ss_q   <= {ss_q[1:0], spi.SS_n};
      sclk_q <= {sclk_q[1:0], spi.SCLK};
      mosi_q <= {mosi_q[0], spi.MOSI};
    end
  // Frame shifting and end-of-frame channel/result capture
  always_ff @(posedge clk)
    if (rst) begin
      rx_shft <= 16'h0000;
      tx_shft <= 16'h0000;
      bit_cnt <= 5'd0;
      chnl    <= 3'd0;
      result  <= 12'h000;
    end else begin
      if (ss_fall) begin
        tx_shft <= {4'h0, result};
        bit_cnt <= 5'd0;
      end else if (ss_low & sclk_rise) begin
        rx_shft <= {rx_shft[14:0], mosi_q[1]};
        bit_cnt <= (bit_cnt == 5'd16) ? bit_cnt : bit_cnt + 5'd1;
      end else if (ss_low & sclk_fall & (bit_cnt != 5'd0))
        tx_shft <= {tx_shft[14:0], 1'b0};
      if (frame_ok) begin
        chnl   <= nxt_chnl;
        result <= sel;
      end
    end
`ifdef ADC_TRISTATE_EN
  assign spi.MISO = ss_low ? tx_shft[15] : 1'bz;
`else
  assign spi.MISO = ss_low ? tx_shft[15] : 1'b0;
`endif
endmodule

// File: tb/tb_adc128s_fc.sv
// tb_adc128s_fc: randomized SPI master against a frame-level model of the A2D
module tb_adc128s_fc;
  logic clk = 0;
  logic rst = 1;
  logic [11:0] lft = 0, rght = 0, steer = 0, batt = 0;
  logic [11:0] m_res = 0;
  logic [15:0] g;
  int checks = 0, failures = 0, hi_cnt = 0;
`ifdef ADC_TRISTATE_EN
  localparam logic IDLE = 1'bz;
`else
  localparam logic IDLE = 1'b0;
`endif
  adc128s_fc_if spi();
  adc128s_fc dut(.clk(clk), .rst(rst), .spi(spi.slave), .ld_cell_lft(lft),
                 .ld_cell_rght(rght), .steerPot(steer), .batt(batt));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  function automatic logic [11:0] chval(input logic [2:0] c);
    case (c)
      3'd0: return lft;
      3'd4: return rght;
      3'd5: return steer;
      3'd6: return batt;
      default: return 12'h000;
    endcase
  endfunction
  always @(negedge clk) begin
    if (hi_cnt >= 4) chk("idle_miso", {15'h0, spi.MISO}, {15'h0, IDLE});
    hi_cnt = spi.SS_n ? hi_cnt + 1 : 0;
  end
  task automatic frame(input logic [15:0] mosi, input int nbits, input bit stir, output logic [15:0] got);
    logic [15:0] exp, mask;
    exp = {4'h0, m_res};
    got = 16'h0;
    spi.SS_n = 0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi.MOSI = mosi[15-i];
      repeat ($urandom_range(4, 6)) @(negedge clk);
      got[15-i] = spi.MISO;
      spi.SCLK = 1;
      if (stir && i == 8) begin
        lft = 12'($urandom); rght = 12'($urandom);
        steer = 12'($urandom); batt = 12'($urandom);
      end
      repeat ($urandom_range(4, 6)) @(negedge clk);
      spi.SCLK = 0;
    end
    repeat (5) @(negedge clk);
    spi.SS_n = 1;
    if (nbits == 16) m_res = chval(mosi[13:11]);
    mask = ~(16'hFFFF >> nbits);
    chk("frame_word", got & mask, exp & mask);
    repeat (4) @(negedge clk);
    repeat (2) begin
      spi.MOSI = 1'($urandom);
      spi.SCLK = 1;
      repeat (5) @(negedge clk);
      spi.SCLK = 0;
      repeat (5) @(negedge clk);
    end
  endtask
  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    spi.SS_n = 1; spi.SCLK = 0; spi.MOSI = 0;
    repeat (2) @(negedge clk);
    chk("reset_miso", {15'h0, spi.MISO}, {15'h0, IDLE});
    rst = 0;
    repeat (4) @(negedge clk);
    frame(16'h0000, 16, 0, g); chk("t1_first", g, 16'h0000);
    lft = 12'h400;
    frame(16'h0000, 16, 0, g); chk("t2_a", g, 16'h0000);
    frame(16'h0000, 16, 0, g); chk("t2_b", g, 16'h0400);
    batt = 12'hFFF; steer = 12'h800;
    frame(16'h3000, 16, 0, g); chk("t3_a", g, 16'h0400);
    frame(16'h2800, 16, 0, g); chk("t3_batt", g, 16'h0FFF);
    rght = 12'h123;
    frame(16'h2000, 16, 0, g); chk("t3_steer", g, 16'h0800);
    frame(16'h1800, 9, 0, g);
    frame(16'h3800, 16, 0, g); chk("t4_after_abort", g, 16'h0123);
    frame(16'h0000, 16, 0, g); chk("t5_ch7", g, 16'h0000);
    spi.SS_n = 0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      spi.MOSI = 1'($urandom);
      repeat (5) @(negedge clk);
      spi.SCLK = 1;
      repeat (5) @(negedge clk);
      spi.SCLK = 0;
    end
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("t6_rst_miso", {15'h0, spi.MISO}, {15'h0, IDLE});
    spi.SS_n = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    m_res = 12'h000;
    repeat (6) @(negedge clk);
    frame(16'h3000, 16, 0, g); chk("t6_after_rst", g, 16'h0000);
    for (int n = 0; n < 40; n++) begin
      frame(16'($urandom), ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 15)) : 16, 1, g);
    end
    frame(16'h0000, 16, 0, g);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
